fir_liczniki: RTL and testbench
===============================

FIR_LICZNIKI -- requirements
Module: fir_liczniki

Interface
REQ-001 Parameter TAP_W, default 5, width of tap index (max 32 taps).
REQ-002 Parameter SAMPLE_W, default 10, width of sample index/address (max 1024 samples).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 cfg_liczba_wsp  input  TAP_W+1  number of taps, valid range 1..2^TAP_W.
REQ-006 cfg_liczba_probek  input  SAMPLE_W+1  samples per run, valid range 1..2^SAMPLE_W.
REQ-007 FSM_reset_licznik  input  1  start-of-run pulse; clears sample counters, latches cfg.
REQ-008 FSM_zapisz_probki  input  1  one sample written to buffer this cycle.
REQ-009 FSM_nowa_probka  input  1  sample processed; advance sample counter.
REQ-010 FSM_reset_petla  input  1  clear tap counter before a MAC loop.
REQ-011 FSM_petla_en  input  1  advance tap counter one MAC step.
REQ-012 Petla_full  output  1  tap loop complete.
REQ-013 Licznik_full  output  1  all samples of run processed.
REQ-014 adres_wsp  output  TAP_W  coefficient read address (= tap index).
REQ-015 adres_probki  output  SAMPLE_W  sample read address (circular, newest minus tap index).
REQ-016 adres_zapisu  output  SAMPLE_W  sample write pointer.
REQ-017 cfg_err  output  1  latched config was zero or out of range.

Function
REQ-018 All outputs SHALL be registered; no combinational path input->output.
REQ-019 On FSM_reset_licznik: latch cfg, clear sample counter, Licznik_full, adres_zapisu; cfg_err set next cycle if either cfg is 0 or exceeds 2^W, else cleared.
REQ-020 Zero or over-range cfg SHALL be clamped to 1 and 2^W respectively.
REQ-021 FSM_zapisz_probki SHALL increment adres_zapisu by 1, wrapping 2^SAMPLE_W-1 -> 0.
REQ-022 Tap counter states: IDLE (idx 0, full 0), RUN, FULL; FSM_reset_petla -> IDLE from any state.
REQ-023 FSM_petla_en in IDLE/RUN: idx+1 next cycle; when idx == taps-1 with en, Petla_full =1 next cycle, idx holds at taps-1, state FULL.
REQ-024 In FULL, FSM_petla_en SHALL be ignored; Petla_full held until FSM_reset_petla.
REQ-025 taps == 1: first FSM_petla_en asserts Petla_full next cycle, idx stays 0.
REQ-026 adres_wsp SHALL equal tap idx, updated same edge as idx.
REQ-027 adres_probki SHALL equal (adres_zapisu - 1 - idx) mod 2^SAMPLE_W, registered same edge as idx.
REQ-028 FSM_nowa_probka SHALL increment sample counter; when it reaches latched cfg_liczba_probek, Licznik_full =1 next cycle, counter saturates, held until FSM_reset_licznik.
REQ-029 Simultaneous reset pulse and enable on same counter: reset wins.
REQ-030 FSM_reset_licznik SHALL NOT affect tap counter; FSM_reset_petla SHALL NOT affect sample counter or adres_zapisu.
REQ-031 FSM_nowa_probka and FSM_petla_en in same cycle SHALL both take effect.

Reset
REQ-032 rst_n low SHALL asynchronously clear all counters, pointers, flags and outputs to 0; latched cfg to 1 tap, 1 sample.
REQ-033 Reset mid-run SHALL abandon the run; after release block is in IDLE awaiting FSM_reset_licznik.

Structure
REQ-034 TAP_W, SAMPLE_W defaults and counter-state enum SHALL live in shared package fir_pkg.
REQ-035 One sub-module fir_licznik: parameterised up-counter with sync clear, enable, terminal value and sticky full flag; instantiated for tap and sample counters.

Verification
REQ-036 taps=4, reset_petla then 6 cycles petla_en -> adres_wsp 0,1,2,3,3,3; Petla_full high from 4th cycle after first en.
REQ-037 taps=1, single petla_en -> Petla_full next cycle, adres_wsp 0.
REQ-038 probek=3, three nowa_probka pulses -> Licznik_full after third; fourth pulse no change; reset_licznik clears it.
REQ-039 adres_zapisu=2 after 2 writes, taps=4, sweep -> adres_probki 1,0,1023,1022 (wrap).
REQ-040 cfg_liczba_wsp=0 latched -> cfg_err=1, Petla_full after first en; reset_petla+petla_en same cycle -> idx 0, full 0.
REQ-041 rst_n asserted mid-loop (idx=2, async, between edges) -> all outputs 0 immediately.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared widths and counter-state encoding for the FIR tap/sample address counters.
package fir_pkg;
   localparam int TAP_W_DEF    = 5;
   localparam int SAMPLE_W_DEF = 10;

   typedef enum logic [1:0] {
      CNT_IDLE = 2'd0,
      CNT_RUN  = 2'd1,
      CNT_FULL = 2'd2
   } cnt_state_t;
endpackage

// File: rtl/fir_licznik.sv
// Up-counter with sync clear, enable and a sticky full flag raised by an enable seen at the terminal value.
// Count and flag update one cycle after clr/en; clr beats en; en is ignored once full until the next clr.
module fir_licznik
   import fir_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic [W-1:0] cnt_nxt,
   output logic         full
);

   cnt_state_t state;
   logic       at_term;

   // >= rather than == so a terminal lowered mid-run cannot be overrun
   assign at_term = (cnt >= term);

   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (en && (state != CNT_FULL) && !at_term)
         cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CNT_IDLE;
         cnt   <= '0;
         full  <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (clr) begin
            state <= CNT_IDLE;
            full  <= 1'b0;
         end else if (en && (state != CNT_FULL)) begin
            if (at_term) begin
               state <= CNT_FULL;
               full  <= 1'b1;
            end else begin
               state <= CNT_RUN;
            end
         end
      end
   end

endmodule

// File: rtl/fir_liczniki.sv
// FIR control counters: tap loop index, per-run sample count and circular sample buffer addresses.
// Every output is a register updated one cycle after its FSM strobe; no flow control, strobes are always accepted.
module fir_liczniki
   import fir_pkg::*;
#(
   parameter int TAP_W    = TAP_W_DEF,
   parameter int SAMPLE_W = SAMPLE_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [TAP_W:0]      cfg_liczba_wsp,
   input  logic [SAMPLE_W:0]   cfg_liczba_probek,
   input  logic                FSM_reset_licznik,
   input  logic                FSM_zapisz_probki,
   input  logic                FSM_nowa_probka,
   input  logic                FSM_reset_petla,
   input  logic                FSM_petla_en,
   output logic                Petla_full,
   output logic                Licznik_full,
   output logic [TAP_W-1:0]    adres_wsp,
   output logic [SAMPLE_W-1:0] adres_probki,
   output logic [SAMPLE_W-1:0] adres_zapisu,
   output logic                cfg_err
);

   localparam logic [TAP_W:0]    WSP_MAX    = {1'b1, {TAP_W{1'b0}}};
   localparam logic [SAMPLE_W:0] PROBEK_MAX = {1'b1, {SAMPLE_W{1'b0}}};

   logic [TAP_W-1:0]    tap_term, tap_term_in, idx_nxt;
   logic [SAMPLE_W-1:0] probek_term, probek_term_in, zap_nxt;
   logic [SAMPLE_W-1:0] probek_cnt_unused, probek_nxt_unused;
   logic                wsp_bad, probek_bad;

   // Terminals are stored as count-1 so the counters compare against W-bit values;
   // the low bits minus one also give the right answer for the full 2^W case.
   always_comb begin
      wsp_bad     = (cfg_liczba_wsp == '0) || (cfg_liczba_wsp > WSP_MAX);
      tap_term_in = cfg_liczba_wsp[TAP_W-1:0] - 1'b1;
      if (cfg_liczba_wsp == '0)
         tap_term_in = '0;
      else if (cfg_liczba_wsp > WSP_MAX)
         tap_term_in = '1;

      probek_bad     = (cfg_liczba_probek == '0) || (cfg_liczba_probek > PROBEK_MAX);
      probek_term_in = cfg_liczba_probek[SAMPLE_W-1:0] - 1'b1;
      if (cfg_liczba_probek == '0)
         probek_term_in = '0;
      else if (cfg_liczba_probek > PROBEK_MAX)
         probek_term_in = '1;

      zap_nxt = adres_zapisu;
      if (FSM_reset_licznik)
         zap_nxt = '0;
      else if (FSM_zapisz_probki)
         zap_nxt = adres_zapisu + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_term     <= '0;
         probek_term  <= '0;
         cfg_err      <= 1'b0;
         adres_zapisu <= '0;
         adres_probki <= '0;
      end else begin
         if (FSM_reset_licznik) begin
            tap_term    <= tap_term_in;
            probek_term <= probek_term_in;
            cfg_err     <= wsp_bad || probek_bad;
         end
         adres_zapisu <= zap_nxt;
         // built from next-state values so it lands on the same edge as adres_wsp
         adres_probki <= zap_nxt - SAMPLE_W'(1) - SAMPLE_W'(idx_nxt);
      end
   end

   fir_licznik #(.W(TAP_W)) u_tap_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (FSM_reset_petla),
      .en      (FSM_petla_en),
      .term    (tap_term),
      .cnt     (adres_wsp),
      .cnt_nxt (idx_nxt),
      .full    (Petla_full)
   );

   fir_licznik #(.W(SAMPLE_W)) u_probek_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (FSM_reset_licznik),
      .en      (FSM_nowa_probka),
      .term    (probek_term),
      .cnt     (probek_cnt_unused),
      .cnt_nxt (probek_nxt_unused),
      .full    (Licznik_full)
   );

endmodule

// File: tb/tb_fir_liczniki.sv
// Directed bench for fir_liczniki: a count-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_fir_liczniki;
   localparam int TAP_W    = 5;
   localparam int SAMPLE_W = 10;
   localparam int NTAP     = 1 << TAP_W;
   localparam int NSAMP    = 1 << SAMPLE_W;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [TAP_W:0]      cfg_liczba_wsp;
   logic [SAMPLE_W:0]   cfg_liczba_probek;
   logic                FSM_reset_licznik, FSM_zapisz_probki, FSM_nowa_probka;
   logic                FSM_reset_petla, FSM_petla_en;
   logic                Petla_full, Licznik_full, cfg_err;
   logic [TAP_W-1:0]    adres_wsp;
   logic [SAMPLE_W-1:0] adres_probki, adres_zapisu;

   int n_checks = 0;
   int n_pass   = 0;

   fir_liczniki #(.TAP_W(TAP_W), .SAMPLE_W(SAMPLE_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_liczba_wsp    (cfg_liczba_wsp),
      .cfg_liczba_probek (cfg_liczba_probek),
      .FSM_reset_licznik (FSM_reset_licznik),
      .FSM_zapisz_probki (FSM_zapisz_probki),
      .FSM_nowa_probka   (FSM_nowa_probka),
      .FSM_reset_petla   (FSM_reset_petla),
      .FSM_petla_en      (FSM_petla_en),
      .Petla_full        (Petla_full),
      .Licznik_full      (Licznik_full),
      .adres_wsp         (adres_wsp),
      .adres_probki      (adres_probki),
      .adres_zapisu      (adres_zapisu),
      .cfg_err           (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
   endtask

   function automatic int clamp(input int v, input int hi);
      return (v == 0) ? 1 : (v > hi) ? hi : v;
   endfunction

   // Reference model: plain counts of taps and samples, addresses as integer arithmetic.
   int m_idx, m_taps, m_cnt, m_nsamp, m_zap;
   bit m_pfull, m_lfull, m_err, m_pv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idx <= 0; m_pfull <= 0; m_taps <= 1; m_cnt <= 0; m_lfull <= 0;
         m_nsamp <= 1; m_zap <= 0; m_err <= 0; m_pv <= 0;
      end else begin
         m_pv <= 1;
         if (FSM_reset_petla) begin
            m_idx <= 0; m_pfull <= 0;
         end else if (FSM_petla_en && !m_pfull) begin
            if (m_idx == m_taps - 1) m_pfull <= 1;
            else m_idx <= m_idx + 1;
         end
         if (FSM_reset_licznik) begin
            m_cnt <= 0; m_lfull <= 0; m_zap <= 0;
            m_taps  <= clamp(int'(cfg_liczba_wsp), NTAP);
            m_nsamp <= clamp(int'(cfg_liczba_probek), NSAMP);
            m_err   <= (cfg_liczba_wsp == 0) || (int'(cfg_liczba_wsp) > NTAP) ||
                       (cfg_liczba_probek == 0) || (int'(cfg_liczba_probek) > NSAMP);
         end else begin
            if (FSM_nowa_probka && !m_lfull) begin
               m_cnt <= m_cnt + 1;
               if (m_cnt + 1 == m_nsamp) m_lfull <= 1;
            end
            if (FSM_zapisz_probki) m_zap <= (m_zap + 1) % NSAMP;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_petla_full",   Petla_full,   m_pfull);
         check("cyc_licznik_full", Licznik_full, m_lfull);
         check("cyc_adres_wsp",    adres_wsp,    m_idx);
         check("cyc_adres_zapisu", adres_zapisu, m_zap);
         check("cyc_cfg_err",      cfg_err,      m_err);
         if (m_pv)
            check("cyc_adres_probki", adres_probki, (m_zap - 1 - m_idx + 2 * NSAMP) % NSAMP);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_petla_full"},   Petla_full,   0);
      check({tag, "_licznik_full"}, Licznik_full, 0);
      check({tag, "_adres_wsp"},    adres_wsp,    0);
      check({tag, "_adres_probki"}, adres_probki, 0);
      check({tag, "_adres_zapisu"}, adres_zapisu, 0);
      check({tag, "_cfg_err"},      cfg_err,      0);
   endtask

   int exp_wsp[6];
   int exp_prb[6];

   initial begin
      exp_wsp = '{0, 1, 2, 3, 3, 3};
      exp_prb = '{1, 0, 1023, 1022, 1022, 1022};
      rst_n = 1'b0;
      cfg_liczba_wsp = 6'd4; cfg_liczba_probek = 11'd3;
      FSM_reset_licznik = 0; FSM_zapisz_probki = 0; FSM_nowa_probka = 0;
      FSM_reset_petla = 0; FSM_petla_en = 0;
      #1 check_all_zero("reset");
      #21 rst_n = 1'b1;
      tick();

      // start a run: 4 taps, 3 samples
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("start_cfg_err", cfg_err, 0);
      FSM_zapisz_probki = 1; tick(); tick(); FSM_zapisz_probki = 0;
      check("two_writes_zapisu", adres_zapisu, 2);

      // tap sweep with probki wrap
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0;
      FSM_petla_en = 1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("sweep_wsp_%0d", k), adres_wsp, exp_wsp[k]);
         check($sformatf("sweep_probki_%0d", k), adres_probki, exp_prb[k]);
         check($sformatf("sweep_full_%0d", k), Petla_full, (k >= 4) ? 1 : 0);
         tick();
      end
      FSM_petla_en = 0;
      check("sweep_end_full", Petla_full, 1);

      // three samples fill the run, fourth changes nothing
      FSM_nowa_probka = 1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("samp_full_%0d", k), Licznik_full, (k >= 3) ? 1 : 0);
      end
      FSM_nowa_probka = 0;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("rl_clears_lfull", Licznik_full, 0);
      check("rl_keeps_pfull", Petla_full, 1);
      check("rl_keeps_wsp", adres_wsp, 3);

      // reset_petla leaves the write pointer; nowa and petla_en together both count
      FSM_zapisz_probki = 1; tick(); FSM_zapisz_probki = 0;
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0;
      check("rp_keeps_zapisu", adres_zapisu, 1);
      check("rp_clears_pfull", Petla_full, 0);
      FSM_nowa_probka = 1; FSM_petla_en = 1; tick(); FSM_petla_en = 0;
      check("both_wsp", adres_wsp, 1);
      check("both_probki", adres_probki, 1023);
      tick();
      check("both_lfull_2", Licznik_full, 0);
      tick();
      check("both_lfull_3", Licznik_full, 1);

      // reset_licznik wins over nowa and zapisz in the same cycle
      FSM_reset_licznik = 1; FSM_zapisz_probki = 1; tick();
      FSM_reset_licznik = 0; FSM_zapisz_probki = 0;
      check("win_lfull", Licznik_full, 0);
      check("win_zapisu", adres_zapisu, 0);
      tick(); tick();
      check("win_lfull_2", Licznik_full, 0);
      tick();
      check("win_lfull_3", Licznik_full, 1);
      FSM_nowa_probka = 0;

      // single tap
      cfg_liczba_wsp = 6'd1;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("t1_cfg_err", cfg_err, 0);
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0;
      FSM_petla_en = 1; tick();
      check("t1_pfull", Petla_full, 1);
      check("t1_wsp", adres_wsp, 0);
      tick(); FSM_petla_en = 0;
      check("t1_hold_wsp", adres_wsp, 0);

      // zero taps clamps to one
      cfg_liczba_wsp = 6'd0;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("t0_cfg_err", cfg_err, 1);
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0;
      FSM_petla_en = 1; tick();
      check("t0_pfull", Petla_full, 1);
      check("t0_wsp", adres_wsp, 0);
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0; FSM_petla_en = 0;
      check("rp_wins_pfull", Petla_full, 0);
      check("rp_wins_wsp", adres_wsp, 0);

      // over-range taps clamp to 32, full sample range is accepted
      cfg_liczba_wsp = 6'd40; cfg_liczba_probek = 11'd1024;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("t40_cfg_err", cfg_err, 1);
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0;
      FSM_petla_en = 1;
      for (int k = 0; k < 31; k++) tick();
      check("t40_wsp_31", adres_wsp, 31);
      check("t40_pfull_31", Petla_full, 0);
      tick(); FSM_petla_en = 0;
      check("t40_pfull_32", Petla_full, 1);
      cfg_liczba_wsp = 6'd32;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("t32_cfg_err", cfg_err, 0);
      cfg_liczba_probek = 11'd0;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("p0_cfg_err", cfg_err, 1);
      FSM_nowa_probka = 1; tick(); FSM_nowa_probka = 0;
      check("p0_lfull", Licznik_full, 1);
      cfg_liczba_probek = 11'd1025;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      check("p1025_cfg_err", cfg_err, 1);

      // asynchronous reset in the middle of a tap loop
      cfg_liczba_wsp = 6'd4; cfg_liczba_probek = 11'd3;
      FSM_reset_licznik = 1; tick(); FSM_reset_licznik = 0;
      FSM_zapisz_probki = 1; tick(); tick(); tick(); FSM_zapisz_probki = 0;
      FSM_reset_petla = 1; tick(); FSM_reset_petla = 0;
      FSM_petla_en = 1; tick(); tick();
      check("mid_wsp_2", adres_wsp, 2);
      #3 rst_n = 1'b0;
      FSM_petla_en = 0;
      #1 check_all_zero("async");
      #2 rst_n = 1'b1;
      tick();
      check("post_wsp", adres_wsp, 0);
      check("post_pfull", Petla_full, 0);
      check("post_zapisu", adres_zapisu, 0);
      check("post_probki", adres_probki, 1023);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
